// File: rtl/prim_ram_2p_fifo_ptr.sv
// -----------------------------------------------------------------------------
// prim_ram_2p_fifo_ptr
// Wrapping RAM address pointer for the FIFO controller: counts 0..Depth-1 and
// wraps back to 0, so Depth need not be a power of two.
//
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous reset, active low (pointer -> 0)
//   clr_i   synchronous clear (pointer -> 0), wins over inc_i
//   inc_i   advance the pointer by one entry
//   ptr_o   current pointer value
// -----------------------------------------------------------------------------
module prim_ram_2p_fifo_ptr #(
   parameter int unsigned Depth = 16,
   localparam int unsigned Aw   = $clog2(Depth)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clr_i,
   input  logic          inc_i,
   output logic [Aw-1:0] ptr_o
);

   logic [Aw-1:0] ptr_q, ptr_d;

   // Next pointer: clear, else wrap at Depth-1, else increment.
   always_comb begin
      ptr_d = ptr_q;
      if (clr_i) begin
         ptr_d = '0;
      end else if (inc_i) begin
         ptr_d = (ptr_q == Aw'(Depth - 1)) ? '0 : ptr_q + Aw'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/prim_ram_2p_fifo.sv
// -----------------------------------------------------------------------------
// prim_ram_2p_fifo
// FIFO controller driving an external 2-port RAM (port A write-only push side,
// port B read-only head prefetch). A one-entry output stage hides the RAM's
// 1-cycle read latency, giving full push+pop throughput and Depth+1 capacity.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   clr_i                     synchronous flush
//   wvalid_i/wready_o/wdata_i push handshake and data
//   rvalid_o/rready_i/rdata_o pop handshake and head data
//   depth_o                   total occupancy (RAM + output stage)
//   ram_a_*                   RAM port A (writes)
//   ram_b_*                   RAM port B (reads), ram_b_rdata_i valid 1 cycle
//                             after ram_b_req_o
// -----------------------------------------------------------------------------
module prim_ram_2p_fifo #(
   parameter int unsigned Width = 32,
   parameter int unsigned Depth = 16,
   localparam int unsigned Aw   = $clog2(Depth),
   localparam int unsigned Dw   = $clog2(Depth + 2)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             wvalid_i,
   output logic             wready_o,
   input  logic [Width-1:0] wdata_i,
   output logic             rvalid_o,
   input  logic             rready_i,
   output logic [Width-1:0] rdata_o,
   output logic [Dw-1:0]    depth_o,
   output logic             ram_a_req_o,
   output logic             ram_a_write_o,
   output logic [Aw-1:0]    ram_a_addr_o,
   output logic [Width-1:0] ram_a_wdata_o,
   output logic [Width-1:0] ram_a_wmask_o,
   output logic             ram_b_req_o,
   output logic             ram_b_write_o,
   output logic [Aw-1:0]    ram_b_addr_o,
   output logic [Width-1:0] ram_b_wdata_o,
   output logic [Width-1:0] ram_b_wmask_o,
   input  logic [Width-1:0] ram_b_rdata_i
);

   logic             push, pop, fetch, head_valid;
   logic [Aw-1:0]    wptr, rptr;
   logic [Dw-1:0]    ram_cnt_q, ram_cnt_d;
   logic             fetch_pend_q, fetch_pend_d;
   logic             out_valid_q, out_valid_d;
   logic [Width-1:0] out_q, out_d;

   // Handshakes: the head is either in flight from the RAM or held in out_q.
   assign head_valid = fetch_pend_q | out_valid_q;
   assign wready_o   = (ram_cnt_q != Dw'(Depth)) && !clr_i;
   assign push       = wvalid_i && wready_o;
   assign rvalid_o   = head_valid;
   assign rdata_o    = fetch_pend_q ? ram_b_rdata_i : out_q;
   assign pop        = head_valid && rready_i;
   // Refill the head slot whenever it is empty or being vacated this cycle.
   assign fetch      = (ram_cnt_q != '0) && (!head_valid || pop) && !clr_i;
   assign depth_o    = ram_cnt_q + Dw'(head_valid);

   // RAM port A: push side.
   assign ram_a_req_o   = push;
   assign ram_a_write_o = 1'b1;
   assign ram_a_addr_o  = wptr;
   assign ram_a_wdata_o = wdata_i;
   assign ram_a_wmask_o = '1;

   // RAM port B: head prefetch, never writes.
   assign ram_b_req_o   = fetch;
   assign ram_b_write_o = 1'b0;
   assign ram_b_addr_o  = rptr;
   assign ram_b_wdata_o = '0;
   assign ram_b_wmask_o = '0;

   prim_ram_2p_fifo_ptr #(.Depth(Depth)) u_wptr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (clr_i),
      .inc_i  (push),
      .ptr_o  (wptr)
   );

   prim_ram_2p_fifo_ptr #(.Depth(Depth)) u_rptr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (clr_i),
      .inc_i  (fetch),
      .ptr_o  (rptr)
   );

   // RAM occupancy: entries written but not yet fetched.
   always_comb begin
      ram_cnt_d = ram_cnt_q;
      if (clr_i) begin
         ram_cnt_d = '0;
      end else if (push && !fetch) begin
         ram_cnt_d = ram_cnt_q + Dw'(1);
      end else if (fetch && !push) begin
         ram_cnt_d = ram_cnt_q - Dw'(1);
      end
   end

   // Output stage: capture RAM data only if the in-flight head was not popped.
   always_comb begin
      fetch_pend_d = fetch_pend_q;
      out_valid_d  = out_valid_q;
      out_d        = out_q;
      if (clr_i) begin
         fetch_pend_d = 1'b0;
         out_valid_d  = 1'b0;
         out_d        = '0;
      end else if (fetch) begin
         fetch_pend_d = 1'b1;
         out_valid_d  = 1'b0;
      end else if (fetch_pend_q && !pop) begin
         out_d        = ram_b_rdata_i;
         out_valid_d  = 1'b1;
         fetch_pend_d = 1'b0;
      end else if (pop) begin
         out_valid_d  = 1'b0;
         fetch_pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ram_cnt_q    <= '0;
         fetch_pend_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_q        <= '0;
      end else begin
         ram_cnt_q    <= ram_cnt_d;
         fetch_pend_q <= fetch_pend_d;
         out_valid_q  <= out_valid_d;
         out_q        <= out_d;
      end
   end

endmodule
